// File: rtl/sqr_wave_meter.sv
// sqr_wave_meter: measures high/low phase lengths of a square wave in TICK_DIV-cycle units
module sqr_wave_meter #(
  parameter int TICK_DIV = 10,
  parameter int UNIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic [UNIT_W-1:0] exp_m,
  input  logic [UNIT_W-1:0] exp_n,
  output logic [UNIT_W-1:0] m_meas,
  output logic [UNIT_W-1:0] n_meas,
  output logic              valid,
  output logic              frac_err,
  output logic              ovf,
  output logic              match
);
  localparam int SUB_W = $clog2(TICK_DIV);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_DIV - 1);
  localparam logic [UNIT_W-1:0] UNIT_MAX = '1;
  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t state_q, state_d;
  logic sig_q, rise, fall, edge_hit, wrap, sat, frac, cap, upd, fe_n, ov_n;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [UNIT_W-1:0] units_q, units_d, hm_q, hm_d, m_q, m_d, n_q, n_d;
  logic povf_q, povf_d, hf_q, hf_d, ho_q, ho_d;
  logic fe_q, fe_d, ov_q, ov_d, mt_q, mt_d, v_q, v_d;
  assign rise = sig_in & ~sig_q;
  assign fall = ~sig_in & sig_q;
  assign edge_hit = rise | fall;
  assign wrap = sub_q == SUB_LAST;
  assign sat = units_q == UNIT_MAX;
  assign frac = sub_q != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= 1'b1;
      sub_q   <= '0;
      units_q <= '0;
      povf_q  <= 1'b0;
      hm_q    <= '0;
      hf_q    <= 1'b0;
      ho_q    <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      mt_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_in;
      sub_q   <= sub_d;
      units_q <= units_d;
      povf_q  <= povf_d;
      hm_q    <= hm_d;
      hf_q    <= hf_d;
      ho_q    <= ho_d;
      m_q     <= m_d;
      n_q     <= n_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      mt_q    <= mt_d;
      v_q     <= v_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE      ? (rise ? MEAS_HIGH : IDLE) :
              state_q == MEAS_HIGH ? (fall ? MEAS_LOW : MEAS_HIGH) :
                                     (rise ? MEAS_HIGH : MEAS_LOW);
  end
  // the edge cycle itself counts as the first cycle of the new phase
  always_comb begin
    sub_d   = edge_hit ? SUB_W'(1) : wrap ? '0 : sub_q + 1'b1;
    units_d = edge_hit ? '0 : (wrap && !sat) ? units_q + 1'b1 : units_q;
    povf_d  = edge_hit ? 1'b0 : povf_q | (wrap & sat);
  end
  always_comb begin
    cap  = (state_q == MEAS_HIGH) & fall;
    upd  = (state_q == MEAS_LOW) & rise;
    fe_n = hf_q | frac;
    ov_n = ho_q | povf_q;
    hm_d = cap ? units_q : hm_q;
    hf_d = cap ? frac : hf_q;
    ho_d = cap ? povf_q : ho_q;
    m_d  = upd ? hm_q : m_q;
    n_d  = upd ? units_q : n_q;
    fe_d = upd ? fe_n : fe_q;
    ov_d = upd ? ov_n : ov_q;
    mt_d = upd ? (hm_q == exp_m) & (units_q == exp_n) & ~fe_n & ~ov_n : mt_q;
    v_d  = upd;
  end
  assign m_meas   = m_q;
  assign n_meas   = n_q;
  assign frac_err = fe_q;
  assign ovf      = ov_q;
  assign match    = mt_q;
  assign valid    = v_q;
endmodule

// File: tb/tb_sqr_wave_meter.sv
// tb_sqr_wave_meter: directed square-wave patterns with a queue of expected period results
module tb_sqr_wave_meter;
  typedef struct packed {
    logic [3:0] m;
    logic [3:0] n;
    logic       f;
    logic       o;
    logic       mt;
    int         gap;
  } exp_t;
  logic clk = 1'b0;
  logic rst, sig_in;
  logic [3:0] exp_m, exp_n, m_meas, n_meas;
  logic valid, frac_err, ovf, match;
  exp_t q[$];
  exp_t cur, e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_v = 0;
  sqr_wave_meter dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .exp_m(exp_m), .exp_n(exp_n),
    .m_meas(m_meas), .n_meas(n_meas), .valid(valid), .frac_err(frac_err),
    .ovf(ovf), .match(match)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (valid === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_valid obs=1 exp=0 at cycle %0d", cyc);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert ({m_meas, n_meas, frac_err, ovf, match} === {e.m, e.n, e.f, e.o, e.mt}) else begin
          errors++;
          $error("FAIL update m/n/frac/ovf/match obs=%h/%h/%b/%b/%b exp=%h/%h/%b/%b/%b",
                 m_meas, n_meas, frac_err, ovf, match, e.m, e.n, e.f, e.o, e.mt);
        end
        if (e.gap != 0) begin
          checks++;
          assert (cyc - last_v === e.gap) else begin
            errors++;
            $error("FAIL valid_spacing obs=%0d exp=%0d", cyc - last_v, e.gap);
          end
        end
        cur = e;
        last_v = cyc;
      end
    end else begin
      checks++;
      assert ({m_meas, n_meas, frac_err, ovf, match, valid} === {cur.m, cur.n, cur.f, cur.o, cur.mt, 1'b0}) else begin
        errors++;
        $error("FAIL hold m/n/frac/ovf/match/valid obs=%h/%h/%b/%b/%b/%b exp=%h/%h/%b/%b/%b/0",
               m_meas, n_meas, frac_err, ovf, match, valid, cur.m, cur.n, cur.f, cur.o, cur.mt);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic phase(input logic v, input int cycles);
    sig_in = v;
    repeat (cycles) step();
  endtask
  task automatic expect_period(input int m, input int n, input logic f, input logic o,
                               input logic mt, input int gap);
    exp_t x;
    x.m = 4'(m);
    x.n = 4'(n);
    x.f = f;
    x.o = o;
    x.mt = mt;
    x.gap = gap;
    q.push_back(x);
  endtask
  task automatic do_reset(input logic v, input int cycles);
    rst = 1'b1;
    sig_in = v;
    step();
    cur = '0;
    q.delete();
    repeat (cycles - 1) step();
    rst = 1'b0;
  endtask
  initial begin
    cur = '0;
    exp_m = 4'd3;
    exp_n = 4'd2;
    do_reset(1'b0, 3);
    phase(1'b0, 5);
    phase(1'b1, 30); phase(1'b0, 20);
    expect_period(3, 2, 0, 0, 1, 0);
    phase(1'b1, 30); phase(1'b0, 20);
    expect_period(3, 2, 0, 0, 1, 50);
    phase(1'b1, 25); phase(1'b0, 20);
    expect_period(2, 2, 1, 0, 0, 45);
    phase(1'b1, 200); phase(1'b0, 10);
    expect_period(15, 1, 0, 1, 0, 210);
    phase(1'b1, 5); phase(1'b0, 10);
    expect_period(0, 1, 1, 0, 0, 15);
    phase(1'b1, 20); phase(1'b0, 10);
    exp_m = 4'd2;
    exp_n = 4'd1;
    expect_period(2, 1, 0, 0, 1, 30);
    phase(1'b1, 30); phase(1'b0, 20);
    exp_m = 4'd3;
    exp_n = 4'd2;
    expect_period(3, 2, 0, 0, 1, 50);
    phase(1'b1, 300); phase(1'b0, 10);
    expect_period(15, 1, 0, 1, 0, 310);
    phase(1'b1, 30); phase(1'b0, 10);
    do_reset(1'b0, 2);
    phase(1'b0, 10);
    phase(1'b1, 30); phase(1'b0, 20);
    expect_period(3, 2, 0, 0, 1, 0);
    phase(1'b1, 30); phase(1'b0, 20);
    expect_period(3, 2, 0, 0, 1, 50);
    phase(1'b1, 10);
    do_reset(1'b1, 3);
    phase(1'b1, 15); phase(1'b0, 20);
    phase(1'b1, 30); phase(1'b0, 20);
    expect_period(3, 2, 0, 0, 1, 0);
    phase(1'b1, 5); phase(1'b0, 5);
    phase(1'b0, 10);
    checks++;
    assert (q.size() === 0) else begin
      errors++;
      $error("FAIL pending_updates obs=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
